// File: rtl/ahb_arbiter_rr_if.sv
// Bus bundle between the AHB master ports, the arbiter/mux and the slave path.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface ahb_arbiter_rr_if #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int MW = $clog2(N_MASTERS);

  logic [N_MASTERS-1:0]        m_busreq;
  logic [N_MASTERS-1:0]        m_hlock;
  logic [2*N_MASTERS-1:0]      m_htrans;
  logic [3*N_MASTERS-1:0]      m_hburst;
  logic [3*N_MASTERS-1:0]      m_hsize;
  logic [N_MASTERS-1:0]        m_hwrite;
  logic [ADDR_W*N_MASTERS-1:0] m_haddr;
  logic [DATA_W*N_MASTERS-1:0] m_hwdata;
  logic                        hready;
  logic [1:0]                  hresp;

  logic [N_MASTERS-1:0]        hgrant;
  logic [MW-1:0]               hmaster;
  logic                        hmastlock;
  logic [ADDR_W-1:0]           s_haddr;
  logic [1:0]                  s_htrans;
  logic [2:0]                  s_hburst;
  logic [2:0]                  s_hsize;
  logic                        s_hwrite;
  logic [DATA_W-1:0]           s_hwdata;

  modport slave (
    input  m_busreq, m_hlock, m_htrans, m_hburst, m_hsize, m_hwrite,
           m_haddr, m_hwdata, hready, hresp,
    output hgrant, hmaster, hmastlock, s_haddr, s_htrans, s_hburst,
           s_hsize, s_hwrite, s_hwdata
  );

  modport master (
    output m_busreq, m_hlock, m_htrans, m_hburst, m_hsize, m_hwrite,
           m_haddr, m_hwdata, hready, hresp,
    input  hgrant, hmaster, hmastlock, s_haddr, s_htrans, s_hburst,
           s_hsize, s_hwrite, s_hwdata
  );
endinterface

// File: rtl/ahb_arbiter_rr.sv
// AHB arbiter for N masters (fixed-priority or round-robin) with the master-side
// address/control mux driven by hmaster and the write-data mux driven by the data-phase owner.
module ahb_arbiter_rr #(
  parameter int N_MASTERS      = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int DEFAULT_MASTER = 0,
  parameter int ARB_MODE       = 1
) (
  input  logic            hclk,
  input  logic            hreset,
  ahb_arbiter_rr_if.slave bus
);
  localparam int MW = $clog2(N_MASTERS);
  localparam logic [N_MASTERS-1:0] DEF_GRANT = N_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MW-1:0]        DEF_IDX   = MW'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } hburst_e;

  logic [N_MASTERS-1:0] hgrant_q;
  logic [MW-1:0]        hmaster_q;
  logic [MW-1:0]        owner_q;
  logic                 hmastlock_q;
  logic [4:0]           burst_left_q;
  logic [MW-1:0]        rr_ptr_q;

  logic [MW-1:0]        grant_idx;
  logic [4:0]           burst_next;
  logic                 arb_ok;
  logic [MW-1:0]        winner;
  logic                 found;
  logic [N_MASTERS-1:0] grant_nxt;

  logic [ADDR_W-1:0]    s_haddr;
  logic [1:0]           s_htrans;
  logic [2:0]           s_hburst;
  logic [2:0]           s_hsize;
  logic                 s_hwrite;
  logic [DATA_W-1:0]    s_hwdata;

  function automatic logic [4:0] beats_m1(input logic [2:0] hb);
    case (hburst_e'(hb))
      BU_INCR4,  BU_WRAP4:  beats_m1 = 5'd3;
      BU_INCR8,  BU_WRAP8:  beats_m1 = 5'd7;
      BU_INCR16, BU_WRAP16: beats_m1 = 5'd15;
      default:              beats_m1 = 5'd0;
    endcase
  endfunction

  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (hgrant_q[MW'(i)]) grant_idx = MW'(i);
    end
  end

  always_comb begin
    s_haddr  = '0;
    s_htrans = '0;
    s_hburst = '0;
    s_hsize  = '0;
    s_hwrite = 1'b0;
    s_hwdata = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (hmaster_q == MW'(i)) begin
        s_haddr  = bus.m_haddr[i*ADDR_W +: ADDR_W];
        s_htrans = bus.m_htrans[i*2 +: 2];
        s_hburst = bus.m_hburst[i*3 +: 3];
        s_hsize  = bus.m_hsize[i*3 +: 3];
        s_hwrite = bus.m_hwrite[MW'(i)];
      end
      if (owner_q == MW'(i)) s_hwdata = bus.m_hwdata[i*DATA_W +: DATA_W];
    end
  end

  // Remaining beats after this edge; an error response terminates the burst whatever the transfer type.
  always_comb begin
    burst_next = burst_left_q;
    case (htrans_e'(s_htrans))
      TR_NONSEQ: burst_next = beats_m1(s_hburst);
      TR_SEQ:    burst_next = (burst_left_q == 5'd0) ? 5'd0 : burst_left_q - 5'd1;
      TR_BUSY:   burst_next = burst_left_q;
      default:   burst_next = 5'd0;
    endcase
    if (bus.hresp != 2'b00) burst_next = 5'd0;
  end

  // Re-arbitrate while the last beat's address is on the bus so the new owner follows without a gap.
  assign arb_ok = (burst_next <= 5'd1) && !bus.m_hlock[grant_idx];

  always_comb begin
    logic [MW-1:0] cand;
    int unsigned   pos;
    winner = DEF_IDX;
    found  = 1'b0;
    cand   = '0;
    pos    = 0;
    if (ARB_MODE == 0) begin
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
        if (!found && bus.m_busreq[MW'(i)]) begin
          winner = MW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      // Search starts just after the last winner and ends on it, so a sole requester keeps the bus.
      for (int unsigned k = 1; k <= N_MASTERS; k++) begin
        pos  = (32'(rr_ptr_q) + k) % N_MASTERS;
        cand = MW'(pos);
        if (!found && bus.m_busreq[cand]) begin
          winner = cand;
          found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_nxt         = '0;
    grant_nxt[winner] = 1'b1;
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      hgrant_q     <= DEF_GRANT;
      hmaster_q    <= DEF_IDX;
      owner_q      <= DEF_IDX;
      hmastlock_q  <= 1'b0;
      burst_left_q <= '0;
      rr_ptr_q     <= DEF_IDX;
    end else if (bus.hready) begin
      hmaster_q    <= grant_idx;
      owner_q      <= hmaster_q;
      hmastlock_q  <= bus.m_hlock[grant_idx];
      burst_left_q <= burst_next;
      if (arb_ok) begin
        hgrant_q <= grant_nxt;
        if (found && (winner != grant_idx)) rr_ptr_q <= winner;
      end
    end
  end

  assign bus.hgrant    = hgrant_q;
  assign bus.hmaster   = hmaster_q;
  assign bus.hmastlock = hmastlock_q;
  assign bus.s_haddr   = s_haddr;
  assign bus.s_htrans  = s_htrans;
  assign bus.s_hburst  = s_hburst;
  assign bus.s_hsize   = s_hsize;
  assign bus.s_hwrite  = s_hwrite;
  assign bus.s_hwdata  = s_hwdata;
endmodule

// File: tb/tb_ahb_arbiter_rr.sv
// Bench for ahb_arbiter_rr: a fixed-priority instance (default master 2) and a round-robin
// instance (default master 0) share one stimulus set; expectations are queued per cycle.
module tb_ahb_arbiter_rr;
  localparam logic [1:0] T_IDLE = 2'd0, T_NS = 2'd2, T_SQ = 2'd3;
  localparam logic [2:0] B_INCR4 = 3'd3, B_INCR8 = 3'd5, B_INCR16 = 3'd7;

  logic        hclk;
  logic        hreset;
  logic [3:0]  busreq, hlock;
  logic [7:0]  htrans;
  logic [11:0] hburst;
  logic        hready;
  logic [1:0]  hresp;
  logic        use_rr;
  logic [127:0] haddr_all, hwdata_all;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      tag;
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
    logic [1:0] owner;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [1:0] exp_master, exp_owner;

  ahb_arbiter_rr_if #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32)) bus_fp ();
  ahb_arbiter_rr_if #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32)) bus_rr ();

  ahb_arbiter_rr #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .DEFAULT_MASTER(2), .ARB_MODE(0))
    dut_fp (.hclk(hclk), .hreset(hreset), .bus(bus_fp));
  ahb_arbiter_rr #(.N_MASTERS(4), .ADDR_W(32), .DATA_W(32), .DEFAULT_MASTER(0), .ARB_MODE(1))
    dut_rr (.hclk(hclk), .hreset(hreset), .bus(bus_rr));

  function automatic logic [31:0] addr_of(input int m);
    addr_of = 32'h1000_0000 + 32'(m) * 32'h100;
  endfunction

  function automatic logic [31:0] wd_of(input int m);
    wd_of = 32'hDA7A_0000 + 32'(m);
  endfunction

  function automatic logic [7:0] tr_of(input int m, input logic [1:0] t);
    tr_of = '0;
    tr_of[2*m +: 2] = t;
  endfunction

  function automatic logic [11:0] bu_of(input int m, input logic [2:0] b);
    bu_of = '0;
    bu_of[3*m +: 3] = b;
  endfunction

  assign bus_fp.m_busreq = busreq;
  assign bus_fp.m_hlock  = hlock;
  assign bus_fp.m_htrans = htrans;
  assign bus_fp.m_hburst = hburst;
  assign bus_fp.m_hsize  = {4{3'b010}};
  assign bus_fp.m_hwrite = 4'b0101;
  assign bus_fp.m_haddr  = haddr_all;
  assign bus_fp.m_hwdata = hwdata_all;
  assign bus_fp.hready   = hready;
  assign bus_fp.hresp    = hresp;

  assign bus_rr.m_busreq = busreq;
  assign bus_rr.m_hlock  = hlock;
  assign bus_rr.m_htrans = htrans;
  assign bus_rr.m_hburst = hburst;
  assign bus_rr.m_hsize  = {4{3'b010}};
  assign bus_rr.m_hwrite = 4'b0101;
  assign bus_rr.m_haddr  = haddr_all;
  assign bus_rr.m_hwdata = hwdata_all;
  assign bus_rr.hready   = hready;
  assign bus_rr.hresp    = hresp;

  logic [3:0]  obs_grant;
  logic [1:0]  obs_master;
  logic        obs_lock;
  logic [31:0] obs_haddr, obs_hwdata;
  assign obs_grant  = use_rr ? bus_rr.hgrant    : bus_fp.hgrant;
  assign obs_master = use_rr ? bus_rr.hmaster   : bus_fp.hmaster;
  assign obs_lock   = use_rr ? bus_rr.hmastlock : bus_fp.hmastlock;
  assign obs_haddr  = use_rr ? bus_rr.s_haddr   : bus_fp.s_haddr;
  assign obs_hwdata = use_rr ? bus_rr.s_hwdata  : bus_fp.s_hwdata;

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] lck,
                      input logic [7:0] tr, input logic [11:0] bu, input logic rdy,
                      input logic [1:0] rsp, input logic [3:0] eg, input logic [1:0] em,
                      input logic el);
    exp_t e;
    @(negedge hclk);
    busreq = req; hlock = lck; htrans = tr; hburst = bu; hready = rdy; hresp = rsp;
    if (rdy) begin
      exp_owner  = exp_master;
      exp_master = em;
    end
    e.tag = tag; e.grant = eg; e.master = em; e.lock = el; e.owner = exp_owner;
    sb_q.push_back(e);
  endtask

  always @(posedge hclk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.tag, ".hgrant"},    32'(obs_grant),  32'(mon_e.grant));
      check({mon_e.tag, ".hmaster"},   32'(obs_master), 32'(mon_e.master));
      check({mon_e.tag, ".hmastlock"}, 32'(obs_lock),   32'(mon_e.lock));
      check({mon_e.tag, ".s_haddr"},   obs_haddr,       addr_of(int'(mon_e.master)));
      check({mon_e.tag, ".s_hwdata"},  obs_hwdata,      wd_of(int'(mon_e.owner)));
    end
  end

  task automatic idle_inputs();
    busreq = '0; hlock = '0; htrans = '0; hburst = '0; hready = 1'b1; hresp = 2'b00;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      haddr_all[32*i +: 32]  = addr_of(i);
      hwdata_all[32*i +: 32] = wd_of(i);
    end
    idle_inputs();
    use_rr = 1'b0;
    hreset = 1'b1;
    #2 hreset = 1'b0;
    #5;
    check("fp_rst.hgrant",    32'(obs_grant),  32'h4);
    check("fp_rst.hmaster",   32'(obs_master), 32'd2);
    check("fp_rst.hmastlock", 32'(obs_lock),   32'd0);
    check("fp_rst.s_haddr",   obs_haddr,       addr_of(2));
    check("fp_rst.s_hwdata",  obs_hwdata,      wd_of(2));
    exp_master = 2'd2; exp_owner = 2'd2;
    @(negedge hclk) hreset = 1'b1;

    // Fixed priority: lowest index wins, default master when idle, frozen while hready is low.
    step("fp_idle0", 4'b0000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b0);
    step("fp_idle1", 4'b0000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b0);
    step("fp_1010a", 4'b1010, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0010, 2'd2, 1'b0);
    step("fp_1010b", 4'b1010, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0010, 2'd1, 1'b0);
    step("fp_1000a", 4'b1000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b1000, 2'd1, 1'b0);
    step("fp_1000b", 4'b1000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b1000, 2'd3, 1'b0);
    step("fp_1111a", 4'b1111, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0001, 2'd3, 1'b0);
    step("fp_1111b", 4'b1111, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);
    step("fp_stall", 4'b0110, 4'b0, 8'h00, 12'h0, 1'b0, 2'b00, 4'b0001, 2'd0, 1'b0);
    step("fp_0110",  4'b0110, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0);
    step("fp_dflt0", 4'b0000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0100, 2'd1, 1'b0);
    step("fp_dflt1", 4'b0000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b0);

    @(negedge hclk);
    idle_inputs();
    use_rr = 1'b1;
    hreset = 1'b0;
    #2;
    check("rr_rst.hgrant",    32'(obs_grant),  32'h1);
    check("rr_rst.hmaster",   32'(obs_master), 32'd0);
    check("rr_rst.hmastlock", 32'(obs_lock),   32'd0);
    exp_master = 2'd0; exp_owner = 2'd0;
    @(negedge hclk) hreset = 1'b1;

    // Round-robin rotation with SINGLE transfers from every master.
    step("rr_rot1", 4'b1111, 4'b0, 8'hAA, 12'h0, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0);
    step("rr_rot2", 4'b1111, 4'b0, 8'hAA, 12'h0, 1'b1, 2'b00, 4'b0100, 2'd1, 1'b0);
    step("rr_rot3", 4'b1111, 4'b0, 8'hAA, 12'h0, 1'b1, 2'b00, 4'b1000, 2'd2, 1'b0);
    step("rr_rot4", 4'b1111, 4'b0, 8'hAA, 12'h0, 1'b1, 2'b00, 4'b0001, 2'd3, 1'b0);
    step("rr_rot5", 4'b1111, 4'b0, 8'hAA, 12'h0, 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0);
    step("rr_dfl0", 4'b0000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0001, 2'd1, 1'b0);
    step("rr_dfl1", 4'b0000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);

    // Master 0 INCR8 with master 1 waiting: hand-over on the beat-6 edge.
    step("b8_ns", 4'b0011, 4'b0, tr_of(0, T_NS), bu_of(0, B_INCR8), 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);
    repeat (5)
      step("b8_sq", 4'b0010, 4'b0, tr_of(0, T_SQ), bu_of(0, B_INCR8), 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);
    step("b8_b6", 4'b0010, 4'b0, tr_of(0, T_SQ), bu_of(0, B_INCR8), 1'b1, 2'b00, 4'b0010, 2'd0, 1'b0);
    step("b8_b7", 4'b0010, 4'b0, tr_of(0, T_SQ), bu_of(0, B_INCR8), 1'b1, 2'b00, 4'b0010, 2'd1, 1'b0);

    // Master 1 INCR8 with three wait states mid-burst.
    step("w8_ns", 4'b0011, 4'b0, tr_of(1, T_NS), bu_of(1, B_INCR8), 1'b1, 2'b00, 4'b0010, 2'd1, 1'b0);
    repeat (3)
      step("w8_sq", 4'b0001, 4'b0, tr_of(1, T_SQ), bu_of(1, B_INCR8), 1'b1, 2'b00, 4'b0010, 2'd1, 1'b0);
    repeat (3)
      step("w8_wait", 4'b0001, 4'b0, tr_of(1, T_SQ), bu_of(1, B_INCR8), 1'b0, 2'b00, 4'b0010, 2'd1, 1'b0);
    repeat (2)
      step("w8_sq", 4'b0001, 4'b0, tr_of(1, T_SQ), bu_of(1, B_INCR8), 1'b1, 2'b00, 4'b0010, 2'd1, 1'b0);
    step("w8_b6", 4'b0001, 4'b0, tr_of(1, T_SQ), bu_of(1, B_INCR8), 1'b1, 2'b00, 4'b0001, 2'd1, 1'b0);
    step("w8_b7", 4'b0001, 4'b0, tr_of(1, T_SQ), bu_of(1, B_INCR8), 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);

    // Master 0 INCR16 terminated by ERROR at beat 4; master 3 takes over on that edge.
    step("er_ns", 4'b1001, 4'b0, tr_of(0, T_NS), bu_of(0, B_INCR16), 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);
    repeat (3)
      step("er_sq", 4'b1000, 4'b0, tr_of(0, T_SQ), bu_of(0, B_INCR16), 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);
    step("er_err", 4'b1000, 4'b0, tr_of(0, T_SQ), bu_of(0, B_INCR16), 1'b1, 2'b01, 4'b1000, 2'd0, 1'b0);
    step("er_aft", 4'b1000, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b1000, 2'd3, 1'b0);

    // Master 3 INCR16 cut short by IDLE at beat 5; master 2 waiting.
    step("id_ns", 4'b1100, 4'b0, tr_of(3, T_NS), bu_of(3, B_INCR16), 1'b1, 2'b00, 4'b1000, 2'd3, 1'b0);
    repeat (4)
      step("id_sq", 4'b0100, 4'b0, tr_of(3, T_SQ), bu_of(3, B_INCR16), 1'b1, 2'b00, 4'b1000, 2'd3, 1'b0);
    step("id_idle", 4'b0100, 4'b0, 8'h00, bu_of(3, B_INCR16), 1'b1, 2'b00, 4'b0100, 2'd3, 1'b0);
    step("id_aft",  4'b0100, 4'b0, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0100, 2'd2, 1'b0);

    // Master 2 locked across two INCR4 bursts while master 0 requests.
    for (int b = 0; b < 2; b++) begin
      step("lk_ns", 4'b0101, 4'b0100, tr_of(2, T_NS), bu_of(2, B_INCR4), 1'b1, 2'b00, 4'b0100, 2'd2, 1'b1);
      repeat (3)
        step("lk_sq", 4'b0101, 4'b0100, tr_of(2, T_SQ), bu_of(2, B_INCR4), 1'b1, 2'b00, 4'b0100, 2'd2, 1'b1);
    end
    step("lk_drop", 4'b0001, 4'b0000, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0001, 2'd2, 1'b0);
    step("lk_aft",  4'b0001, 4'b0000, 8'h00, 12'h0, 1'b1, 2'b00, 4'b0001, 2'd0, 1'b0);

    @(posedge hclk);
    #3;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end
endmodule

// File: doc/ahb_arbiter_rr.md
Name: ahb_arbiter_rr

Overview:
Parametrised AHB bus arbiter and master-side multiplexer for N masters sharing one AHB slave path. Grant selection is either fixed-priority or round-robin. Grant is held for the full length of fixed-length bursts and for locked sequences. Early burst termination (IDLE, or a non-OKAY response) releases the grant. The block drives the address/control mux from hmaster and the write-data mux from a registered data-phase owner; it sits between the master ports and the address decoder/slave mux.

Parameters:
N_MASTERS, 4, number of masters (2..16)
ADDR_W, 32, address width
DATA_W, 32, write-data width
DEFAULT_MASTER, 0, master granted at reset and when no requests are pending
ARB_MODE, 1, 0 = fixed priority (index 0 highest), 1 = round-robin
MW (localparam), $clog2(N_MASTERS), master index width

Ports:
hclk  in  1  bus clock
hreset  in  1  asynchronous active-low reset
m_busreq  in  N_MASTERS  per-master bus request
m_hlock  in  N_MASTERS  per-master lock request
m_htrans  in  2*N_MASTERS  per-master HTRANS, packed, master i at [2i+1:2i]
m_hburst  in  3*N_MASTERS  per-master HBURST, packed
m_hsize  in  3*N_MASTERS  per-master HSIZE, packed
m_hwrite  in  N_MASTERS  per-master HWRITE
m_haddr  in  ADDR_W*N_MASTERS  per-master address, packed
m_hwdata  in  DATA_W*N_MASTERS  per-master write data, packed
hready  in  1  HREADY from the slave mux
hresp  in  2  HRESP from the slave mux
hgrant  out  N_MASTERS  one-hot grant, registered
hmaster  out  MW  address-phase owner, registered
hmastlock  out  1  locked-transfer indicator, registered
s_haddr  out  ADDR_W  muxed address (from hmaster)
s_htrans  out  2  muxed HTRANS (from hmaster)
s_hburst  out  3  muxed HBURST (from hmaster)
s_hsize  out  3  muxed HSIZE (from hmaster)
s_hwrite  out  1  muxed HWRITE (from hmaster)
s_hwdata  out  DATA_W  muxed write data (from data-phase owner)

Behaviour:
- Reset (hreset=0, async):
  - hgrant = one-hot(DEFAULT_MASTER); hmaster = DEFAULT_MASTER; data owner = DEFAULT_MASTER.
  - hmastlock = 0; burst_left = 0; rr_ptr = DEFAULT_MASTER.
  - s_* outputs track the default master combinationally.
- State updates occur only on hclk edges with hready=1 (accept edges). All registers hold when hready=0.
- Pipeline: at each accept edge, hmaster <= index(hgrant), data owner <= hmaster, hmastlock <= m_hlock[index(hgrant)].
- A grant change reaches the address mux one accept edge later and the write-data mux two accept edges later.
- Burst counter (burst_left, 5 bits), updated on accept edges:
  - s_htrans = NONSEQ: load beats-1 (INCR4/WRAP4: 3; INCR8/WRAP8: 7; INCR16/WRAP16: 15; SINGLE/INCR: 0).
  - SEQ: decrement, saturating at 0.
  - BUSY: hold.
  - IDLE: clear to 0 (early termination).
  - hresp != OKAY on an accept edge: clear to 0, regardless of htrans.
- Arbitration is permitted at an accept edge when both hold:
  - burst_left after this edge's update is <= 1, so the grant moves while the last beat's address is presented;
  - the currently granted master's m_hlock = 0.
- While arbitration is not permitted, hgrant is frozen.
- Selection (ARB_MODE=0): the lowest-index requesting master wins.
- Selection (ARB_MODE=1): search starts at rr_ptr+1 (mod N_MASTERS) and wraps; the first requester wins; rr_ptr <= winner on every grant change. A sole requester keeps the grant.
- No m_busreq bits set: grant DEFAULT_MASTER.
- Simultaneous events: a request arriving in the same cycle as the final SEQ beat is seen by that edge's arbitration. If a lock drops and a burst ends on the same edge, arbitration is permitted.
- An undefined-length INCR gives burst_left = 0, so it may be rearbitrated on any beat; masters needing continuity use m_hlock.
- hgrant is always exactly one-hot. hmaster is always < N_MASTERS.

Test Plan:
- Reset: hreset=0 with DEFAULT_MASTER=2 -> hgrant=4'b0100, hmaster=2, hmastlock=0. After release with no requests, hgrant stays 4'b0100.
- Fixed priority (ARB_MODE=0): m_busreq=4'b1010 -> hgrant=4'b0010 after one accept edge, hmaster=1 after the next; m_busreq=4'b1000 -> hgrant=4'b1000.
- Round-robin (ARB_MODE=1): all four request continuously with SINGLE transfers and hready=1 -> hgrant sequence 0001, 0010, 0100, 1000, 0001.
- Burst hold: master 0 issues INCR8 (NONSEQ + 7 SEQ) while master 1 requests -> hgrant stays 0001 until the edge accepting SEQ beat 6 (burst_left=1), then 0010; hmaster=1 on the edge accepting beat 7. Inserting hready=0 for 3 cycles mid-burst delays the hand-over by 3 cycles.
- Early termination: master 0 INCR16 receives hresp=ERROR at beat 4 -> burst_left=0 and grant moves to requesting master 3 on that edge. A separate IDLE at beat 5 also clears the burst.
- Lock: master 2 holds m_hlock=1 across two INCR4 bursts with master 0 requesting -> hgrant stays 0100 and hmastlock=1 throughout. hlock drops -> hmastlock=0 and grant passes to master 0 at the next permitted edge. s_hwdata follows the data owner, lagging hmaster by one accept edge.
